// File: rtl/bcd_counter_scan.sv
// bcd_counter_scan: N-digit BCD up/down counter with debounced buttons and a multiplexed 7-segment scanner.
// Define BCD_COUNTER_SCAN_LZB_EN to enable leading-zero blanking on the display.
module bcd_counter_scan #(
    parameter int N_DIGITS = 4,
    parameter int DEB_CNT  = 50000,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  BTN_UP,
    input  logic                  BTN_DOWN,
    input  logic                  CLR,
    output logic [4*N_DIGITS-1:0] count_bcd,
    output logic                  wrap,
    output logic [6:0]            led7segk,
    output logic [N_DIGITS-1:0]   led7sega
);
    localparam int DW = $clog2(DEB_CNT);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CNT - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(N_DIGITS - 1);

    logic [1:0]          w_btn;
    logic [1:0]          w_step;
    logic [1:0]          r_vld;
    logic [1:0]          r_s1;
    logic [1:0]          r_s2;
    logic [1:0]          r_deb;
    logic [1:0]          r_deb_d;
    logic [1:0]          r_arm;
    logic [DW-1:0]       r_dcnt [2];
    logic [4*N_DIGITS-1:0] r_count;
    logic                r_wrap;
    logic [4*N_DIGITS-1:0] w_inc;
    logic [4*N_DIGITS-1:0] w_dec;
    logic                w_carry;
    logic                w_borrow;
    logic [SW-1:0]       r_scan;
    logic [IW-1:0]       r_idx;
    logic [6:0]          r_seg;
    logic [N_DIGITS-1:0] r_an;
    logic                w_tick;
    logic [3:0]          w_digit;
    logic [N_DIGITS-1:0] w_an;
    logic [6:0]          w_seg_raw;
    logic [6:0]          w_seg;

    assign w_btn = {BTN_DOWN, BTN_UP};
    // A button is armed only once it has been sampled low after reset, so a press held through reset never counts.
    assign w_step = r_deb & ~r_deb_d & r_arm;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_vld   <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            r_arm   <= '0;
            for (int b = 0; b < 2; b++) r_dcnt[b] <= '0;
        end else begin
            r_vld   <= {r_vld[0], 1'b1};
            r_s1    <= w_btn;
            r_s2    <= r_s1;
            r_deb_d <= r_deb;
            for (int b = 0; b < 2; b++) begin
                if (r_vld[1] && !r_s2[b]) r_arm[b] <= 1'b1;
                if (r_s2[b] == r_deb[b]) begin
                    r_dcnt[b] <= '0;
                end else if (r_dcnt[b] == DEB_MAX) begin
                    r_deb[b]  <= r_s2[b];
                    r_dcnt[b] <= '0;
                end else begin
                    r_dcnt[b] <= r_dcnt[b] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_inc    = r_count;
        w_dec    = r_count;
        w_carry  = 1'b1;
        w_borrow = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            w_inc[4*k+:4] = w_carry ? ((r_count[4*k+:4] == 4'd9) ? 4'd0 : r_count[4*k+:4] + 4'd1) : r_count[4*k+:4];
            w_dec[4*k+:4] = w_borrow ? ((r_count[4*k+:4] == 4'd0) ? 4'd9 : r_count[4*k+:4] - 4'd1) : r_count[4*k+:4];
            w_carry  = w_carry & (r_count[4*k+:4] == 4'd9);
            w_borrow = w_borrow & (r_count[4*k+:4] == 4'd0);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (CLR) begin
                r_count <= '0;
            end else if (w_step[0] && !w_step[1]) begin
                r_count <= w_inc;
                r_wrap  <= w_carry;
            end else if (w_step[1] && !w_step[0]) begin
                r_count <= w_dec;
                r_wrap  <= w_borrow;
            end
        end
    end

    assign w_tick = (r_scan == SCAN_MAX);

    always_comb begin
        w_digit = 4'd0;
        w_an    = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (IW'(k) == r_idx) begin
                w_digit = r_count[4*k+:4];
                w_an[k] = 1'b0;
            end
        end
    end

    always_comb begin
        case (w_digit)
            4'd0:    w_seg_raw = 7'h40;
            4'd1:    w_seg_raw = 7'h79;
            4'd2:    w_seg_raw = 7'h24;
            4'd3:    w_seg_raw = 7'h30;
            4'd4:    w_seg_raw = 7'h19;
            4'd5:    w_seg_raw = 7'h12;
            4'd6:    w_seg_raw = 7'h02;
            4'd7:    w_seg_raw = 7'h78;
            4'd8:    w_seg_raw = 7'h00;
            4'd9:    w_seg_raw = 7'h10;
            default: w_seg_raw = 7'h7F;
        endcase
    end

`ifdef BCD_COUNTER_SCAN_LZB_EN
    logic w_lz;
    // Digit k is a leading zero when it and every more significant digit are zero.
    always_comb begin
        w_lz = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (IW'(k) >= r_idx && r_count[4*k+:4] != 4'd0) w_lz = 1'b0;
        end
        w_seg = (r_idx != '0 && w_lz) ? 7'h7F : w_seg_raw;
    end
`else
    assign w_seg = w_seg_raw;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_scan <= '0;
            r_idx  <= '0;
            r_seg  <= 7'h7F;
            r_an   <= '1;
        end else begin
            r_scan <= w_tick ? '0 : r_scan + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
                r_seg <= w_seg;
                r_an  <= w_an;
            end
        end
    end

    assign count_bcd = r_count;
    assign wrap      = r_wrap;
    assign led7segk  = r_seg;
    assign led7sega  = r_an;
endmodule

// File: doc/bcd_counter_scan.md
Name: bcd_counter_scan

Overview:
- Parametrised successor to the single-button 0-9999 counter with its 4-digit display.
- N-digit BCD up/down counter with debounced UP/DOWN buttons, synchronous clear, wrap/borrow pulse and an integrated multiplexed 7-segment scanner.
- Counts natively in BCD, so no divide-by-10 datapath is needed.
- Sits at board top level between the push-buttons and the 7-segment pins.

Parameters:
- N_DIGITS, 4, number of BCD digits and anodes (1..8).
- DEB_CNT, 50000, consecutive stable clocks before a synchronised button level is accepted (>=2).
- SCAN_DIV, 50000, clocks per display digit slot (>=2).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  synchronous reset, active-low.
- BTN_UP  in  1  raw up button, active-high, asynchronous.
- BTN_DOWN  in  1  raw down button, active-high, asynchronous.
- CLR  in  1  synchronous clear, active-high, already in the CLK domain.
- count_bcd  out  4*N_DIGITS  current count; digit k at bits [4k+3:4k]; digit 0 is least significant.
- wrap  out  1  one-cycle pulse on 9..9->0..0 increment or 0..0->9..9 decrement.
- led7segk  out  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
- led7sega  out  N_DIGITS  anodes, active-low; bit k drives digit k.

Behaviour:
- Reset (RST_N low at a CLK edge) sets:
  - count_bcd=0, wrap=0, led7segk=7'h7F, led7sega all 1s;
  - debounce counters 0, debounced levels 0, scan counter 0, digit index 0.
- Reset asserted mid-press or mid-scan discards all in-flight state. A button still held after reset release must go low and then high again before it counts.
- Button path, per button:
  - 2-flop synchroniser.
  - Stability counter resets whenever the synchronised level differs from the debounced level. Once it reaches DEB_CNT-1, the debounced level takes the new value.
  - A 0->1 transition of the debounced level yields a 1-cycle step pulse.
  - Press-to-count latency is DEB_CNT+3 clocks from the raw edge.
- Count update priority, per cycle: CLR > (up and down together) > up > down.
  - CLR: count_bcd=0, wrap=0.
  - Up and down pulses in the same cycle: no change, no wrap.
  - Up: BCD increment with ripple carry across digits. All-9s -> all-0s and wrap=1 on that cycle.
  - Down: BCD decrement with ripple borrow. All-0s -> all-9s and wrap=1.
  - count_bcd changes 1 clock after the step pulse. Every digit is always in 0..9.
- Scan:
  - Free-running counter 0..SCAN_DIV-1. Terminal count gives a 1-cycle tick.
  - Each tick: digit index advances (N_DIGITS-1 wraps to 0); led7sega gets bit index low and all others high; led7segk gets the decode of that digit at that same edge.
  - First tick after reset displays digit 0. Outputs stay blank until then.
  - led7segk and led7sega are registered and change on the same edge, so no ghosting.
- Segment decode:
  - Standard active-low codes: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Any other code gives 7'h7F (blank).
- Count changes mid-scan appear at the next tick. No latching of a count snapshot per frame.

Optional Feature:
- Macro: BCD_COUNTER_SCAN_LZB_EN.
- Defined (leading-zero blanking):
  - While digit k is displayed, led7segk=7'h7F if k>0 and digits k..N_DIGITS-1 are all 0.
  - Digit 0 is never blanked, so a count of 0 shows a single "0".
  - Anodes still sequence normally.
- Undefined: all digits are always displayed, including leading zeros.

Test Plan:
- Bench settings: N_DIGITS=4, DEB_CNT=4, SCAN_DIV=8 unless stated.
- Reset: hold RST_N=0 for 3 clocks with BTN_UP=1 -> count_bcd=16'h0000, led7sega=4'hF, led7segk=7'h7F. After release, no count until BTN_UP drops and rises again.
- Debounce: BTN_UP toggled every 2 clocks for 20 clocks, then held high 10 clocks -> exactly one increment, count_bcd=16'h0001, 7 clocks after the final rise.
- Carry and wrap:
  - From 16'h0099, one up -> 16'h0100.
  - From 16'h9999, one up -> 16'h0000 with wrap=1 for exactly one cycle.
  - From 16'h0000, one down -> 16'h9999 with wrap=1.
- Priority: simultaneous up and down pulses at 16'h0042 -> unchanged. CLR asserted during an up pulse -> 16'h0000, wrap=0.
- Scan with count 16'h1234:
  - Anodes cycle 4'hE,4'hD,4'hB,4'h7 every 8 clocks.
  - led7segk shows 7'h19,7'h30,7'h24,7'h79 respectively, aligned on the same edge.
- LZB (macro defined), count 16'h0005: digits 3..1 give 7'h7F and digit 0 gives 7'h12. Same stimulus without the macro gives 7'h40 on digits 3..1.
